// File: rtl/arb_request_buffer_if.sv
// Bundles the producer push ports, the arbiter req/grant handshake and the
// single forwarded output stream of arb_request_buffer.
interface arb_request_buffer_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SrcW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            in_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data_i;
  logic [NUM_REQ-1:0]            in_ready_o;
  logic [NUM_REQ-1:0]            req_o;
  logic                          allow_o;
  logic [NUM_REQ-1:0]            gnt_i;
  logic                          out_valid_o;
  logic [DATA_WIDTH-1:0]         out_data_o;
  logic [SrcW-1:0]               out_src_o;
  logic                          out_ready_i;
  logic                          gnt_err_o;

  // Producers, arbiter and downstream consumer seen as one driving party
  modport master (
    output in_valid_i, in_data_i, gnt_i, out_ready_i,
    input  in_ready_o, req_o, allow_o, out_valid_o, out_data_o, out_src_o, gnt_err_o
  );

  modport slave (
    input  in_valid_i, in_data_i, gnt_i, out_ready_i,
    output in_ready_o, req_o, allow_o, out_valid_o, out_data_o, out_src_o, gnt_err_o
  );
endinterface

// File: rtl/arb_request_buffer.sv
// Per-source payload FIFOs feeding a round-robin arbiter; the granted head is
// forwarded through one registered output slot, with a sticky grant-error flag.
module arb_request_buffer #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  arb_request_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SrcW = $clog2(NUM_REQ);

  logic [DATA_WIDTH-1:0] mem_q    [NUM_REQ][DEPTH];
  logic [PtrW-1:0]       rd_ptr_q [NUM_REQ];
  logic [PtrW-1:0]       wr_ptr_q [NUM_REQ];
  logic [CntW-1:0]       cnt_q    [NUM_REQ];

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SrcW-1:0]       out_src_q;
  logic                  gnt_err_q;

  logic [NUM_REQ-1:0] req_c, ready_c, push_c, pop_c, gnt_acc_c;
  logic               allow_c, pop_any_c, err_c;
  logic [SrcW-1:0]    sel_c;

  // Request and ready come from registered occupancy only
  always_comb begin
    req_c   = '0;
    ready_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_c[i]   = (cnt_q[i] != '0);
      ready_c[i] = (cnt_q[i] != CntW'(DEPTH));
    end
  end

  // Grant qualification: lowest legal grant bit wins, illegal bits only flag
  always_comb begin
    allow_c   = ~out_valid_q | bus.out_ready_i;
    gnt_acc_c = bus.gnt_i & req_c;
    sel_c     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (gnt_acc_c[i]) sel_c = SrcW'(i);
    end
    pop_any_c = allow_c & (|gnt_acc_c);
    pop_c     = '0;
    if (pop_any_c) pop_c[sel_c] = 1'b1;
    push_c    = bus.in_valid_i & ready_c;
    err_c     = ($countones(bus.gnt_i) > 1)
              | (|(bus.gnt_i & ~req_c))
              | ((|bus.gnt_i) & ~allow_c);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (push_c[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop_c[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        case ({push_c[i], pop_c[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CntW'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CntW'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      if (pop_any_c) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem_q[sel_c][rd_ptr_q[sel_c]];
        out_src_q   <= sel_c;
      end else if (bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (err_c) gnt_err_q <= 1'b1;
    end
  end

  // Payload storage needs no reset; pointers and counts define what is live
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (push_c[i]) mem_q[i][wr_ptr_q[i]] <= bus.in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.in_ready_o  = ready_c;
  assign bus.req_o       = req_c;
  assign bus.allow_o     = allow_c;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_src_o   = out_src_q;
  assign bus.gnt_err_o   = gnt_err_q;
endmodule

// File: tb/tb_arb_request_buffer.sv
// Scoreboard bench for arb_request_buffer: queue-based reference model, directed
// scenarios followed by randomized traffic with the bench acting as arbiter.
module tb_arb_request_buffer;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DEPTH      = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  arb_request_buffer_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  arb_request_buffer #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          src;
  } item_t;

  logic [31:0] mq [NUM_REQ][$];
  item_t       exp_q[$];
  bit          m_out_valid;
  bit          m_err;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NUM_REQ-1:0] m_req();
    logic [NUM_REQ-1:0] r;
    for (int i = 0; i < NUM_REQ; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] m_ready();
    logic [NUM_REQ-1:0] r;
    for (int i = 0; i < NUM_REQ; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  function automatic bit m_allow();
    return !m_out_valid || bus.out_ready_i;
  endfunction

  // Reference model: advance one clock edge using the inputs currently applied
  task automatic model_step();
    logic [NUM_REQ-1:0] req, rdy;
    int    sel;
    bit    allow;
    item_t it;
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
      exp_q.delete();
      m_out_valid = 1'b0;
      m_err       = 1'b0;
      return;
    end
    req   = m_req();
    rdy   = m_ready();
    allow = m_allow();
    if ($countones(bus.gnt_i) > 1 || (bus.gnt_i & ~req) != 0 || (bus.gnt_i != 0 && !allow))
      m_err = 1'b1;
    sel = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.gnt_i[i] && req[i]) sel = i;
    if (allow && sel >= 0) begin
      it.data = mq[sel].pop_front();
      it.src  = sel;
      exp_q.push_back(it);
      m_out_valid = 1'b1;
    end else if (bus.out_ready_i) begin
      m_out_valid = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.in_valid_i[i] && rdy[i]) mq[i].push_back(bus.in_data_i[i*DATA_WIDTH +: DATA_WIDTH]);
  endtask

  // Monitor: compares status every cycle and the output slot against the scoreboard
  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("req_o", 64'(bus.req_o), 64'(m_req()));
      chk("in_ready_o", 64'(bus.in_ready_o), 64'(m_ready()));
      chk("allow_o", 64'(bus.allow_o), 64'(m_allow()));
      chk("out_valid_o", 64'(bus.out_valid_o), 64'(m_out_valid));
      chk("gnt_err_o", 64'(bus.gnt_err_o), 64'(m_err));
      if (bus.out_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_item: got data 0x%0h with no expected item at %0t", bus.out_data_o, $time);
        end else begin
          chk("out_data_o", 64'(bus.out_data_o), 64'(exp_q[0].data));
          chk("out_src_o", 64'(bus.out_src_o), 64'(exp_q[0].src));
          if (bus.out_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
    model_step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_in(input logic [NUM_REQ-1:0] v, input int src, input logic [31:0] d);
    bus.in_valid_i = v;
    bus.in_data_i[src*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  function automatic logic [NUM_REQ-1:0] pick_grant();
    logic [NUM_REQ-1:0] req;
    int start;
    req   = m_req();
    start = int'($urandom_range(0, NUM_REQ - 1));
    for (int k = 0; k < NUM_REQ; k++)
      if (req[(start + k) % NUM_REQ]) return NUM_REQ'(1) << ((start + k) % NUM_REQ);
    return '0;
  endfunction

  initial begin
    bus.in_valid_i  = '0;
    bus.in_data_i   = '0;
    bus.gnt_i       = '0;
    bus.out_ready_i = 1'b1;
    rst_ni          = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    rst_ni = 1'b1;

    // Idle after reset
    chk("idle_req", 64'(bus.req_o), 64'h0);
    chk("idle_ready", 64'(bus.in_ready_o), 64'hF);
    chk("idle_allow", 64'(bus.allow_o), 64'h1);
    chk("idle_valid", 64'(bus.out_valid_o), 64'h0);
    chk("idle_err", 64'(bus.gnt_err_o), 64'h0);

    // Fill source 0, overflow push dropped, then drain in order
    for (int k = 0; k < 5; k++) begin
      set_in(4'b0001, 0, 32'hA0 + 32'(k));
      tick();
      if (k == 3) chk("full_ready0", 64'(bus.in_ready_o[0]), 64'h0);
    end
    bus.in_valid_i = '0;
    for (int k = 0; k < 4; k++) begin
      bus.gnt_i = 4'b0001;
      tick();
      if (k == 0) chk("first_out", 64'(bus.out_data_o), 64'hA0);
      if (k == 3) chk("last_out", 64'(bus.out_data_o), 64'hA3);
    end
    bus.gnt_i = '0;
    chk("drained_req0", 64'(bus.req_o[0]), 64'h0);
    tick();

    // Sources 0,2,3 granted back to back
    bus.in_data_i = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    bus.in_valid_i = 4'b1101;
    tick();
    bus.in_valid_i = '0;
    chk("req_1101", 64'(bus.req_o), 64'hD);
    bus.gnt_i = 4'b0001; tick(); chk("src_0", 64'(bus.out_src_o), 64'h0);
    bus.gnt_i = 4'b0100; tick(); chk("src_2", 64'(bus.out_src_o), 64'h2);
    bus.gnt_i = 4'b1000; tick(); chk("src_3", 64'(bus.out_src_o), 64'h3);
    bus.gnt_i = '0;
    chk("no_err", 64'(bus.gnt_err_o), 64'h0);

    // Stall output, push source 1, then grant while not allowed
    bus.out_ready_i = 1'b0;
    set_in(4'b0010, 1, 32'hB1);
    tick();
    bus.in_valid_i = '0;
    tick(); tick();
    chk("stall_allow", 64'(bus.allow_o), 64'h0);
    chk("stall_data", 64'(bus.out_data_o), 64'hD3);
    bus.gnt_i = 4'b0010;
    tick();
    bus.gnt_i = '0;
    chk("stall_err", 64'(bus.gnt_err_o), 64'h1);
    chk("stall_nopop", 64'(bus.req_o[1]), 64'h1);
    bus.out_ready_i = 1'b1;
    tick();
    bus.gnt_i = 4'b0010; tick(); bus.gnt_i = '0; tick();

    // Clear error, then multi-hot and unrequested grants
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    bus.in_data_i = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    bus.in_valid_i = 4'b0110;
    tick();
    bus.in_valid_i = '0;
    bus.gnt_i = 4'b0110;
    tick();
    chk("multi_src", 64'(bus.out_src_o), 64'h1);
    chk("multi_err", 64'(bus.gnt_err_o), 64'h1);
    chk("multi_req", 64'(bus.req_o), 64'h4);
    bus.gnt_i = 4'b1000;
    tick();
    bus.gnt_i = '0;
    chk("unreq_req", 64'(bus.req_o), 64'h4);
    chk("unreq_err", 64'(bus.gnt_err_o), 64'h1);

    // Reset mid-stream discards buffered payloads
    for (int k = 0; k < 3; k++) begin
      set_in(4'b0010, 1, 32'hE0 + 32'(k));
      tick();
    end
    bus.in_valid_i = '0;
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    chk("rst_req", 64'(bus.req_o), 64'h0);
    chk("rst_valid", 64'(bus.out_valid_o), 64'h0);
    chk("rst_err", 64'(bus.gnt_err_o), 64'h0);
    set_in(4'b0010, 1, 32'h55);
    tick();
    bus.in_valid_i = '0;
    bus.gnt_i = 4'b0010;
    tick();
    bus.gnt_i = '0;
    chk("post_rst_out", 64'(bus.out_data_o), 64'h55);
    tick();

    // Randomized traffic with the bench acting as arbiter
    for (int c = 0; c < 800; c++) begin
      int unsigned r;
      bus.in_valid_i  = NUM_REQ'($urandom);
      bus.in_data_i   = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      rst_ni = (r != 0);
      if (r < 5)            bus.gnt_i = NUM_REQ'($urandom);
      else if (r < 150 && m_allow()) bus.gnt_i = pick_grant();
      else                  bus.gnt_i = '0;
      tick();
    end
    rst_ni = 1'b1;

    // Drain everything
    bus.in_valid_i  = '0;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 24; c++) begin
      bus.gnt_i = pick_grant();
      tick();
    end
    bus.gnt_i = '0;
    tick(); tick();
    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    chk("end_req", 64'(bus.req_o), 64'h0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
